// File: rtl/sysmgr_rst_seq.sv
// Reset sequencer for the PLL core clock: syncs lock, stretches reset,
// and generates a divided-rate clock-enable strobe while running.
module sysmgr_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 16,
  parameter int CE_DIV      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  input  logic sw_rst_req,
  output logic rst_out,
  output logic ready,
  output logic ce,
  output logic [((CE_DIV > 1) ? $clog2(CE_DIV) : 1)-1:0] ce_phase
);

  localparam int PW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(CE_DIV - 1);

  typedef enum logic [1:0] {
    HOLD,
    COUNT,
    RUN
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] ph_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic lock_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s = sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      HOLD: begin
        if (lock_s) begin
          state_nxt = COUNT;
          cnt_nxt   = '0;
        end
      end
      COUNT: begin
        if (!lock_s)
          state_nxt = HOLD;
        else if (cnt == CNT_MAX)
          state_nxt = RUN;
        else
          cnt_nxt = cnt + CW'(1);
      end
      RUN: begin
        // lock loss wins over a concurrent software request
        if (!lock_s) begin
          state_nxt = HOLD;
        end else if (sw_rst_req) begin
          state_nxt = COUNT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  always_comb begin
    ph_nxt = '0;
    if (state == RUN && state_nxt == RUN)
      ph_nxt = (ce_phase == PH_MAX) ? '0 : ce_phase + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HOLD;
      cnt      <= '0;
      rst_out  <= 1'b1;
      ready    <= 1'b0;
      ce       <= 1'b0;
      ce_phase <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rst_out  <= (state_nxt != RUN);
      ready    <= (state_nxt == RUN);
      ce_phase <= ph_nxt;
      ce       <= (state_nxt == RUN) && (ph_nxt == PH_MAX);
    end
  end

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// Directed bench for sysmgr_rst_seq: default build plus a
// CE_DIV=1 / RST_CYCLES=1 build.
module tb_sysmgr_rst_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pll_lock, sw_rst_req;
  logic rst_out, ready, ce;
  logic [1:0] ce_phase;

  logic rst1, lock1, sw1;
  logic rst_out1, ready1, ce1;
  logic [0:0] ce_phase1;

  int n_tests = 0;
  int n_fail  = 0;

  sysmgr_rst_seq dut0 (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .ready      (ready),
    .ce         (ce),
    .ce_phase   (ce_phase)
  );

  sysmgr_rst_seq #(
    .SYNC_STAGES (2),
    .RST_CYCLES  (1),
    .CE_DIV      (1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst1),
    .pll_lock   (lock1),
    .sw_rst_req (sw1),
    .rst_out    (rst_out1),
    .ready      (ready1),
    .ce         (ce1),
    .ce_phase   (ce_phase1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lock already high and seen from edge 1: release lands on edge 19
  task automatic expect_release(input string tag);
    for (int i = 1; i <= 18; i++) begin
      step();
      chk({tag, "_hold"}, 32'(rst_out), 32'd1);
    end
    step();
    chk({tag, "_rel"}, 32'(rst_out), 32'd0);
    chk({tag, "_rdy"}, 32'(ready), 32'd1);
    chk({tag, "_ph0"}, 32'(ce_phase), 32'd0);
    chk({tag, "_ce0"}, 32'(ce), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b1; sw_rst_req = 1'b0;
    rst1 = 1'b1; lock1 = 1'b1; sw1 = 1'b0;
    step();
    chk("rst_rst_out", 32'(rst_out), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_phase", 32'(ce_phase), 32'd0);
    chk("rst1_rst_out", 32'(rst_out1), 32'd1);

    // 1: steady lock, release and ce cadence
    rst = 1'b0;
    expect_release("t1");
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("t1_phase", 32'(ce_phase), 32'(j % 4));
      chk("t1_ce", 32'(ce), 32'((j % 4) == 3));
    end

    // 2: no lock for 100 cycles, sw request ignored in HOLD
    rst = 1'b1; pll_lock = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 50) sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      if (i % 25 == 0 || i == 51) begin
        chk("t2_rst_out", 32'(rst_out), 32'd1);
        chk("t2_ce", 32'(ce), 32'd0);
      end
    end
    pll_lock = 1'b1;
    expect_release("t2");

    // 3: lock loss in RUN, right at phase 0
    pll_lock = 1'b0;
    step();
    chk("t3_e1", 32'(rst_out), 32'd0);
    step();
    chk("t3_e2", 32'(rst_out), 32'd0);
    chk("t3_e2_ph", 32'(ce_phase), 32'd2);
    step();
    chk("t3_e3", 32'(rst_out), 32'd1);
    chk("t3_e3_rdy", 32'(ready), 32'd0);
    chk("t3_e3_ce", 32'(ce), 32'd0);
    chk("t3_e3_ph", 32'(ce_phase), 32'd0);
    repeat (7) step();
    pll_lock = 1'b1;
    expect_release("t3");

    // 4: sw reset, second pulse mid-COUNT has no effect
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("t4_enter", 32'(rst_out), 32'd1);
    chk("t4_ce", 32'(ce), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      chk("t4_stretch", 32'(rst_out), 32'(i < 16));
    end
    chk("t4_rdy", 32'(ready), 32'd1);

    // 5: async reset mid-RUN (while ce high) and mid-COUNT
    repeat (3) step();
    chk("t5_ce_pre", 32'(ce), 32'd1);
    chk("t5_ph_pre", 32'(ce_phase), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_run_rst_out", 32'(rst_out), 32'd1);
    chk("t5_run_ce", 32'(ce), 32'd0);
    chk("t5_run_rdy", 32'(ready), 32'd0);
    chk("t5_run_ph", 32'(ce_phase), 32'd0);
    #1;
    rst = 1'b0;
    repeat (10) step();
    chk("t5_count", 32'(rst_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_cnt_rst_out", 32'(rst_out), 32'd1);
    rst = 1'b0;
    expect_release("t5");

    // 6: CE_DIV=1, RST_CYCLES=1 build
    rst1 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("t6_hold", 32'(rst_out1), 32'd1);
      chk("t6_hold_ce", 32'(ce1), 32'd0);
    end
    step();
    chk("t6_rel", 32'(rst_out1), 32'd0);
    chk("t6_rdy", 32'(ready1), 32'd1);
    chk("t6_ce", 32'(ce1), 32'd1);
    chk("t6_ph", 32'(ce_phase1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_ce_run", 32'(ce1), 32'd1);
    end
    lock1 = 1'b0;
    step();
    chk("t6_drop_e1", 32'(rst_out1), 32'd0);
    step();
    chk("t6_drop_e2", 32'(ce1), 32'd1);
    sw1 = 1'b1;
    step();
    sw1 = 1'b0;
    chk("t6_both_rst", 32'(rst_out1), 32'd1);
    chk("t6_both_rdy", 32'(ready1), 32'd0);
    chk("t6_both_ce", 32'(ce1), 32'd0);
    repeat (3) step();
    chk("t6_stay", 32'(rst_out1), 32'd1);
    lock1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t6_relock", 32'(rst_out1), 32'(i < 4));
    end
    chk("t6_relock_ce", 32'(ce1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
